// File: rtl/mem_handshake_sequencer.sv
// mem_handshake_sequencer: issues NUM_TXN pattern writes and then NUM_TXN read-backs
// to a memory macro over a 4-phase A/RW/Ack handshake on LANES data lanes. It checks
// the returned data, counts errors and flags a stalled handshake as a timeout.
module mem_handshake_sequencer #(
    parameter int                ADDR_W    = 17,
    parameter int                DATA_W    = 4,
    parameter int                LANES     = 2,
    parameter int                NUM_TXN   = 16,
    parameter logic [ADDR_W-1:0] ADDR_BASE = 17'h11111,
    parameter logic [ADDR_W-1:0] ADDR_INCR = 17'h00001,
    parameter int                GAP       = 4,
    parameter int                TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [ADDR_W-1:0]        A,
    output logic [1:0]               RW,
    output logic [LANES*DATA_W-1:0]  W,
    input  logic [LANES-1:0]         WdataAck,
    input  logic [LANES*DATA_W-1:0]  R,
    output logic [LANES-1:0]         RDataAck,
    input  logic                     Ack,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic [7:0]               err_count
);

    localparam int DW = LANES * DATA_W;
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(LANES + 1);

    localparam logic [1:0] RW_IDLE = 2'b00;
    localparam logic [1:0] RW_WR   = 2'b01;
    localparam logic [1:0] RW_RD   = 2'b10;

    typedef enum logic [3:0] {
        IDLE, W_REQ, W_REL, GAP_W, R_REQ, R_REL, GAP_R, DONE, FAIL
    } state_t;

    state_t              state;
    logic [15:0]         idx;
    logic [ADDR_W-1:0]   txn_addr;
    logic [ADDR_W-1:0]   next_addr;
    logic [TW-1:0]       wait_cnt;
    logic [15:0]         gap_cnt;

    logic                ack_p0, ack_p1;
    logic [LANES-1:0]    wack_p0, wack_p1;
    logic [DW-1:0]       r_p0, r_p1;

    logic [DW-1:0]       exp_pat;
    logic [LANES-1:0]    lane_ok;
    logic                waiting;
    logic                tmo_hit;
    logic                last_txn;
    logic                wr_gap_end;
    logic                rd_gap_end;

    // Expected data for txn idx: lane l carries (idx+1+l) mod 2^DATA_W.
    function automatic logic [DW-1:0] pattern(input logic [15:0] i);
        logic [DW-1:0] v;
        v = '0;
        for (int l = 0; l < LANES; l++) begin
            v[l*DATA_W +: DATA_W] = DATA_W'(i + 16'(l) + 16'd1);
        end
        return v;
    endfunction

    // Number of lanes whose flag is low.
    function automatic logic [CW-1:0] count_low(input logic [LANES-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int l = 0; l < LANES; l++) begin
            if (!v[l]) c = c + CW'(1);
        end
        return c;
    endfunction

    // Error accumulator add, saturating at 255.
    function automatic logic [7:0] sat_add(input logic [7:0] acc, input logic [CW-1:0] n);
        logic [8:0] s;
        s = {1'b0, acc} + 9'(n);
        return (s > 9'd255) ? 8'd255 : s[7:0];
    endfunction

    assign next_addr  = txn_addr + ADDR_INCR;
    assign last_txn   = (idx == 16'(NUM_TXN - 1));
    assign wr_gap_end = ((state == W_REL) && !ack_p1 && (GAP == 0)) ||
                        ((state == GAP_W) && (gap_cnt == 16'(GAP - 1)));
    assign rd_gap_end = ((state == R_REL) && !ack_p1 && (GAP == 0)) ||
                        ((state == GAP_R) && (gap_cnt == 16'(GAP - 1)));
    assign tmo_hit    = waiting && (wait_cnt == TW'(TIMEOUT));

    // Two-flop synchronisers for the macro-side inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_p0  <= 1'b0;
            ack_p1  <= 1'b0;
            wack_p0 <= '0;
            wack_p1 <= '0;
            r_p0    <= '0;
            r_p1    <= '0;
        end else begin
            ack_p0  <= Ack;
            ack_p1  <= ack_p0;
            wack_p0 <= WdataAck;
            wack_p1 <= wack_p0;
            r_p0    <= R;
            r_p1    <= r_p0;
        end
    end

    // Per-lane read-data compare against the current txn's pattern
    always_comb begin
        exp_pat = pattern(idx);
        lane_ok = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_ok[l] = (r_p1[l*DATA_W +: DATA_W] == exp_pat[l*DATA_W +: DATA_W]);
        end
    end

    // Which states are blocked on the handshake (REQ waits for Ack high, REL for low)
    always_comb begin
        waiting = 1'b0;
        case (state)
            W_REQ, R_REQ: waiting = !ack_p1;
            W_REL, R_REL: waiting = ack_p1;
            default:      waiting = 1'b0;
        endcase
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            txn_addr  <= '0;
            wait_cnt  <= '0;
            gap_cnt   <= '0;
            A         <= '0;
            RW        <= RW_IDLE;
            W         <= '0;
            RDataAck  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            err_count <= '0;
        end else if (tmo_hit) begin
            state    <= FAIL;
            A        <= '0;
            RW       <= RW_IDLE;
            W        <= '0;
            RDataAck <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= 1'b0;
            timeout  <= 1'b1;
        end else begin
            if (waiting) wait_cnt <= wait_cnt + TW'(1);
            case (state)
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        state     <= W_REQ;
                        idx       <= '0;
                        txn_addr  <= ADDR_BASE;
                        wait_cnt  <= '0;
                        A         <= ADDR_BASE;
                        RW        <= RW_WR;
                        W         <= pattern(16'd0);
                        RDataAck  <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        timeout   <= 1'b0;
                        err_count <= '0;
                    end
                end
                W_REQ: begin
                    if (ack_p1) begin
                        err_count <= sat_add(err_count, count_low(wack_p1));
                        A         <= '0;
                        RW        <= RW_IDLE;
                        W         <= '0;
                        wait_cnt  <= '0;
                        state     <= W_REL;
                    end
                end
                W_REL, GAP_W: begin
                    if (wr_gap_end) begin
                        wait_cnt <= '0;
                        if (last_txn) begin
                            state    <= R_REQ;
                            idx      <= '0;
                            txn_addr <= ADDR_BASE;
                            A        <= ADDR_BASE;
                            RW       <= RW_RD;
                        end else begin
                            state    <= W_REQ;
                            idx      <= idx + 16'd1;
                            txn_addr <= next_addr;
                            A        <= next_addr;
                            RW       <= RW_WR;
                            W        <= pattern(idx + 16'd1);
                        end
                    end else if (state == GAP_W) begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end else if (!ack_p1) begin
                        state   <= GAP_W;
                        gap_cnt <= '0;
                    end
                end
                R_REQ: begin
                    if (ack_p1) begin
                        err_count <= sat_add(err_count, count_low(lane_ok));
                        RDataAck  <= '1;
                        A         <= '0;
                        RW        <= RW_IDLE;
                        wait_cnt  <= '0;
                        state     <= R_REL;
                    end
                end
                R_REL, GAP_R: begin
                    if (rd_gap_end) begin
                        RDataAck <= '0;
                        wait_cnt <= '0;
                        if (last_txn) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == 8'd0);
                        end else begin
                            state    <= R_REQ;
                            idx      <= idx + 16'd1;
                            txn_addr <= next_addr;
                            A        <= next_addr;
                            RW       <= RW_RD;
                        end
                    end else if (state == GAP_R) begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end else if (!ack_p1) begin
                        RDataAck <= '0;
                        state    <= GAP_R;
                        gap_cnt  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_handshake_sequencer.sv
// Directed bench for mem_handshake_sequencer: a behavioural macro model answers the
// handshake; expected values are worked out by hand from the data/address pattern.
module tb_mem_handshake_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    // main instance (defaults)
    logic        start = 1'b0;
    logic [16:0] a;
    logic [1:0]  rw;
    logic [7:0]  w;
    logic [1:0]  wdataack;
    logic [7:0]  r;
    logic [1:0]  rdataack;
    logic        ack;
    logic        busy, done, pass, timeout;
    logic [7:0]  err_count;

    // wrap instance (base 1FFFF, two txns, no gap)
    logic        start2 = 1'b0;
    logic [16:0] a2;
    logic [1:0]  rw2;
    logic [7:0]  w2;
    logic [1:0]  wdataack2;
    logic [7:0]  r2;
    logic [1:0]  rdataack2;
    logic        ack2;
    logic        busy2, done2, pass2, timeout2;
    logic [7:0]  err_count2;

    mem_handshake_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .A(a), .RW(rw), .W(w),
        .WdataAck(wdataack), .R(r), .RDataAck(rdataack), .Ack(ack),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count)
    );

    mem_handshake_sequencer #(
        .ADDR_BASE(17'h1FFFF), .NUM_TXN(2), .GAP(0)
    ) u_wrap (
        .clk(clk), .rst(rst), .start(start2), .A(a2), .RW(rw2), .W(w2),
        .WdataAck(wdataack2), .R(r2), .RDataAck(rdataack2), .Ack(ack2),
        .busy(busy2), .done(done2), .pass(pass2), .timeout(timeout2), .err_count(err_count2)
    );

    // ---------------- macro model, main instance ----------------
    logic        ack_en   = 1'b1;
    logic        corrupt  = 1'b0;
    logic [1:0]  wack_mode = 2'b11;
    logic [7:0]  mem [0:31];
    logic [2:0]  dly;
    logic [16:0] wr_log [$];
    int          n_rd = 0;
    logic        rw11_seen = 1'b0;

    // Ack rises 3 cycles after a request appears and falls once RW returns to idle
    always @(posedge clk) begin
        if (rst) begin
            ack      <= 1'b0;
            dly      <= '0;
            r        <= '0;
            wdataack <= '0;
        end else if (rw == 2'b00) begin
            ack <= 1'b0;
            dly <= '0;
        end else if (!ack && ack_en) begin
            if (dly == 3'd2) begin
                ack <= 1'b1;
                if (rw == 2'b01) begin
                    mem[a[4:0]] <= w;
                    wdataack    <= wack_mode;
                    wr_log.push_back(a);
                end else begin
                    r    <= (corrupt && a == 17'h11116) ? (mem[a[4:0]] ^ 8'h10) : mem[a[4:0]];
                    n_rd <= n_rd + 1;
                end
            end else begin
                dly <= dly + 3'd1;
            end
        end
    end

    always @(posedge clk) if (rw == 2'b11 || rw2 == 2'b11) rw11_seen <= 1'b1;

    // ---------------- macro model, wrap instance ----------------
    logic [7:0]  mem2 [0:1];
    logic [2:0]  dly2;
    logic [16:0] wr_log2 [$];

    always @(posedge clk) begin
        if (rst) begin
            ack2      <= 1'b0;
            dly2      <= '0;
            r2        <= '0;
            wdataack2 <= '0;
        end else if (rw2 == 2'b00) begin
            ack2 <= 1'b0;
            dly2 <= '0;
        end else if (!ack2) begin
            if (dly2 == 3'd2) begin
                ack2 <= 1'b1;
                if (rw2 == 2'b01) begin
                    mem2[a2[0]] <= w2;
                    wdataack2   <= 2'b11;
                    wr_log2.push_back(a2);
                end else begin
                    r2 <= mem2[a2[0]];
                end
            end else begin
                dly2 <= dly2 + 3'd1;
            end
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_start2();
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    bit ok;
    int cyc;

    initial begin
        // reset state
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check_val("rst_rw", rw, 0);
        check_val("rst_a", a, 0);
        check_val("rst_busy_done", {busy, done, pass, timeout}, 0);
        check_val("rst_err", err_count, 0);
        @(negedge clk) rst = 1'b0;

        // 1: ideal memory
        wr_log.delete();
        n_rd = 0;
        pulse_start();
        check_val("t1_busy", busy, 1);
        wait_done(3000, ok);
        check_val("t1_finished", ok, 1);
        check_val("t1_done_pass", {done, pass, timeout}, 3'b110);
        check_val("t1_err", err_count, 0);
        check_val("t1_nwr", wr_log.size(), 16);
        check_val("t1_nrd", n_rd, 16);
        check_val("t1_addr_first", wr_log[0], 17'h11111);
        check_val("t1_addr_last", wr_log[15], 17'h11120);
        check_val("t1_data_txn0", mem[5'h11], 8'h21);
        check_val("t1_data_txn5", mem[5'h16], 8'h76);
        check_val("t1_data_txn15", mem[5'h00], 8'h10);
        check_val("t1_idle_bus", {rw, rdataack, busy}, 0);

        // 2: lane 1 of read txn 5 corrupted
        corrupt = 1'b1;
        pulse_start();
        wait_done(3000, ok);
        check_val("t2_finished", ok, 1);
        check_val("t2_err", err_count, 1);
        check_val("t2_pass", pass, 0);
        corrupt = 1'b0;

        // 4: lane 1 never accepts write data
        wack_mode = 2'b01;
        pulse_start();
        wait_done(3000, ok);
        check_val("t4_finished", ok, 1);
        check_val("t4_err", err_count, 16);
        check_val("t4_pass", pass, 0);
        wack_mode = 2'b11;

        // 3: Ack never comes -> timeout in W_REQ
        ack_en = 1'b0;
        pulse_start();
        cyc = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            cyc++;
            if (timeout) break;
        end
        check_val("t3_timeout", timeout, 1);
        check_val("t3_latency", cyc, 256);
        check_val("t3_rw", rw, 0);
        check_val("t3_flags", {busy, done, pass}, 3'b010);
        ack_en = 1'b1;

        // 5: address wrap on the second instance
        wr_log2.delete();
        pulse_start2();
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (done2) begin ok = 1'b1; break; end
        end
        check_val("t5_finished", ok, 1);
        check_val("t5_nwr", wr_log2.size(), 2);
        check_val("t5_addr0", wr_log2[0], 17'h1FFFF);
        check_val("t5_addr1", wr_log2[1], 17'h00000);
        check_val("t5_data", {mem2[1], mem2[0]}, 16'h2132);
        check_val("t5_pass", {pass2, err_count2}, 9'h100);

        // 6: reset while a read request is open, then a clean rerun
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (rw == 2'b10) begin ok = 1'b1; break; end
        end
        check_val("t6_reached_rreq", ok, 1);
        #1 rst = 1'b1;
        #1;
        check_val("t6_async_a_rw_w", {a, rw, w}, 0);
        check_val("t6_async_flags", {rdataack, busy, done, pass, timeout}, 0);
        check_val("t6_async_err", err_count, 0);
        @(negedge clk) rst = 1'b0;
        pulse_start();
        wait_done(3000, ok);
        check_val("t6_rerun_finished", ok, 1);
        check_val("t6_rerun_pass", {pass, err_count}, 9'h100);

        check_val("rw_never_11", rw11_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
